// File: rtl/adder_serial.sv
// Multi-cycle adder/subtractor: sums CHUNK_WIDTH bits per clock with a rippled
// carry register and presents the result behind a valid/ready handshake.
module adder_serial #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    input  logic                  carry_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] resultado,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  zero
);

    localparam int NUM_CHUNKS = (CHUNK_WIDTH > 0) ? DATA_WIDTH / CHUNK_WIDTH : 0;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int MSB        = DATA_WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    generate
        if (CHUNK_WIDTH < 1 || NUM_CHUNKS < 1 || (DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_cfg
            $error("adder_serial: DATA_WIDTH must be a positive multiple of CHUNK_WIDTH");
        end
    endgenerate

    // state   | meaning
    // S_IDLE  | waiting for operands, in_ready high
    // S_CALC  | summing one chunk per clock, LSB chunk first
    // S_DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic                    carry_q, carry_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic                    cout_q, cout_d;
    logic                    ovf_q, ovf_d;
    logic                    zero_q, zero_d;
    logic [CHUNK_WIDTH:0]    chunk_sum;
    int                      base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        res_d     = res_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        base      = int'(idx_q) * CHUNK_WIDTH;
        chunk_sum = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, so the inverted operand is what gets stored.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : carry_in;
                    idx_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                chunk_sum = {1'b0, a_q[base +: CHUNK_WIDTH]}
                          + {1'b0, b_q[base +: CHUNK_WIDTH]}
                          + {{CHUNK_WIDTH{1'b0}}, carry_q};
                res_d[base +: CHUNK_WIDTH] = chunk_sum[CHUNK_WIDTH-1:0];
                carry_d = chunk_sum[CHUNK_WIDTH];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Flags look at res_d so the final chunk is included.
                    cout_d  = chunk_sum[CHUNK_WIDTH];
                    ovf_d   = (a_q[MSB] == b_q[MSB]) && (res_d[MSB] != a_q[MSB]);
                    zero_d  = (res_d == '0);
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign resultado = res_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_adder_serial.sv
// Self-checking bench for adder_serial: vector table through a scoreboard on the
// default configuration, hand sequences for handshake/reset corners, width sweep.
module tb_adder_serial;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        sub = 1'b0, carry_in = 1'b0;

    logic        in_valid_m = 1'b0, out_ready_m = 1'b0;
    logic        in_ready_m, out_valid_m, cout_m, ovf_m, zero_m;
    logic [31:0] res_m;

    logic [2:0]  in_valid_s = '0;
    logic        sweep_ready = 1'b1;
    logic [2:0]  in_ready_s, out_valid_s, cout_s, ovf_s, zero_s;
    logic [31:0] res_s0, res_s1;
    logic [15:0] res_s2;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t sb[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    adder_serial #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid_m), .in_ready(in_ready_m),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .out_valid(out_valid_m), .out_ready(out_ready_m), .resultado(res_m),
        .carry_out(cout_m), .overflow(ovf_m), .zero(zero_m));

    adder_serial #(.DATA_WIDTH(32), .CHUNK_WIDTH(32)) u_sw0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .out_valid(out_valid_s[0]), .out_ready(sweep_ready), .resultado(res_s0),
        .carry_out(cout_s[0]), .overflow(ovf_s[0]), .zero(zero_s[0]));

    adder_serial #(.DATA_WIDTH(32), .CHUNK_WIDTH(4)) u_sw1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .out_valid(out_valid_s[1]), .out_ready(sweep_ready), .resultado(res_s1),
        .carry_out(cout_s[1]), .overflow(ovf_s[1]), .zero(zero_s[1]));

    adder_serial #(.DATA_WIDTH(16), .CHUNK_WIDTH(8)) u_sw2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .a(a[15:0]), .b(b[15:0]), .sub(sub), .carry_in(carry_in),
        .out_valid(out_valid_s[2]), .out_ready(sweep_ready), .resultado(res_s2),
        .carry_out(cout_s[2]), .overflow(ovf_s[2]), .zero(zero_s[2]));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Straight full-width arithmetic, independent of how the DUT chunks it.
    function automatic vec_t model(input logic [31:0] oa, input logic [31:0] ob,
                                   input logic os, input logic oc, input int w);
        vec_t        r;
        logic [63:0] mask, aa, bb, sum;
        mask   = (64'd1 << w) - 64'd1;
        aa     = {32'h0, oa} & mask;
        bb     = (os ? ~{32'h0, ob} : {32'h0, ob}) & mask;
        sum    = aa + bb + {63'd0, (os ? 1'b1 : oc)};
        r.a    = oa;
        r.b    = ob;
        r.sub  = os;
        r.cin  = oc;
        r.res  = 32'(sum & mask);
        r.cout = sum[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
        r.zero = ((sum & mask) == 64'd0);
        return r;
    endfunction

    // Called at a negedge with the main DUT idle; returns at the negedge after acceptance.
    task automatic start_op(input vec_t v);
        a = v.a; b = v.b; sub = v.sub; carry_in = v.cin;
        in_valid_m = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        in_valid_m = 1'b0;
        a = ~v.a; b = ~v.b; sub = ~v.sub; carry_in = ~v.cin;
    endtask

    task automatic finish_op(input int exp_lat, input bit bp, input bit overlap, input vec_t nv);
        int   lat;
        vec_t e;
        lat = 0;
        while (!out_valid_m && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        if (!out_valid_m) return;
        e = sb.pop_front();
        chk("resultado", 64'(res_m), 64'(e.res));
        chk("carry_out", 64'(cout_m), 64'(e.cout));
        chk("overflow", 64'(ovf_m), 64'(e.ovf));
        chk("zero", 64'(zero_m), 64'(e.zero));
        if (bp) begin
            for (int i = 0; i < 10; i++) begin
                out_ready_m = 1'b0;
                in_valid_m  = i[0];
                a = $urandom; b = $urandom; sub = i[1]; carry_in = i[2];
                @(negedge clk);
                chk("bp_out_valid", 64'(out_valid_m), 64'd1);
                chk("bp_in_ready", 64'(in_ready_m), 64'd0);
                chk("bp_resultado", 64'(res_m), 64'(e.res));
            end
            in_valid_m = 1'b0;
        end
        out_ready_m = 1'b1;
        if (overlap) begin
            a = nv.a; b = nv.b; sub = nv.sub; carry_in = nv.cin;
            in_valid_m = 1'b1;
            sb.push_back(nv);
        end
        @(negedge clk);
        out_ready_m = 1'b0;
        chk("hs_in_ready", 64'(in_ready_m), 64'd1);
        chk("hs_out_valid", 64'(out_valid_m), 64'd0);
        chk("hold_resultado", 64'(res_m), 64'(e.res));
        chk("hold_zero", 64'(zero_m), 64'(e.zero));
        if (overlap) begin
            @(negedge clk);
            in_valid_m = 1'b0;
            a = ~nv.a; b = ~nv.b;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, e32, e16, ew;
        int   nc[3];
        bit   done[3];
        int   seen;
        nc[0] = 1; nc[1] = 8; nc[2] = 2;

        //               a             b             sub   cin   res           cout  ovf   zero
        vecs[0]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_000F, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h0000_000A, 32'h0000_000A, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 1'b0, 1'b0};

        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", 64'(in_ready_m), 64'd1);
        chk("rst_out_valid", 64'(out_valid_m), 64'd0);
        chk("rst_resultado", 64'(res_m), 64'd0);
        chk("rst_carry_out", 64'(cout_m), 64'd0);
        chk("rst_overflow", 64'(ovf_m), 64'd0);
        chk("rst_zero", 64'(zero_m), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First operation lands on the first rising edge after reset release.
        foreach (vecs[i]) begin
            start_op(vecs[i]);
            finish_op(4, 1'b0, 1'b0, vecs[i]);
        end

        for (int i = 0; i < 6; i++) begin
            v = model($urandom, $urandom, 1'(i % 2), 1'($urandom_range(0, 1)), 32);
            start_op(v);
            finish_op(4, 1'b0, 1'b0, v);
        end

        // Back-pressure with in_valid pulses, then a new op held valid across the handshake edge.
        start_op(vecs[2]);
        finish_op(4, 1'b1, 1'b1, vecs[9]);
        finish_op(4, 1'b0, 1'b0, vecs[9]);

        // Abort mid-calculation.
        start_op(model(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 32));
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_resultado", 64'(res_m), 64'd0);
        chk("abort_in_ready", 64'(in_ready_m), 64'd1);
        chk("abort_out_valid", 64'(out_valid_m), 64'd0);
        chk("abort_flags", 64'({cout_m, ovf_m, zero_m}), 64'd0);
        void'(sb.pop_front());
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid_m) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        // Width sweep against the reference model.
        for (int r = 0; r < 10; r++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); carry_in = 1'($urandom_range(0, 1));
            if (r == 0) begin a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; carry_in = 1'b0; end
            if (r == 1) begin a = 32'h0000_7FFF; b = 32'h0000_0001; sub = 1'b0; carry_in = 1'b0; end
            e32 = model(a, b, sub, carry_in, 32);
            e16 = model(a, b, sub, carry_in, 16);
            in_valid_s = 3'b111;
            @(negedge clk);
            in_valid_s = 3'b000;
            a = ~a; b = ~b;
            done[0] = 1'b0; done[1] = 1'b0; done[2] = 1'b0;
            for (int lat = 0; lat < 16; lat++) begin
                for (int k = 0; k < 3; k++) begin
                    if (out_valid_s[k] && !done[k]) begin
                        done[k] = 1'b1;
                        ew = (k == 2) ? e16 : e32;
                        chk($sformatf("sweep%0d_latency", k), 64'(lat), 64'(nc[k]));
                        chk($sformatf("sweep%0d_flags", k), 64'({cout_s[k], ovf_s[k], zero_s[k]}),
                            64'({ew.cout, ew.ovf, ew.zero}));
                        case (k)
                            0:       chk("sweep0_res", 64'(res_s0), 64'(ew.res));
                            1:       chk("sweep1_res", 64'(res_s1), 64'(ew.res));
                            default: chk("sweep2_res", 64'(res_s2), 64'(ew.res));
                        endcase
                    end
                end
                @(negedge clk);
            end
            chk("sweep_done", 64'({done[2], done[1], done[0]}), 64'd7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
